mem_rd_streamer: RTL and testbench

//  Consumer of the 7-bit address count: walks a synchronous-read SRAM from addr 0 to NUM_WORDS-1 on start_i,

---
 rtl/mem_rd_streamer.sv | 159 +++++++++++++++
 tb/tb_mem_rd_streamer.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_rd_streamer.sv
// mem_rd_streamer: walks a sync-read SRAM 0..NUM_WORDS-1 and streams words out on valid/ready.
// Ports: clk, rst (async high), start_i, busy_o, done_o, mem_rd_o/mem_addr_o/mem_rdata_i (SRAM),
//   m_valid_o/m_ready_i/m_data_o/m_last_o (stream). Option macro PERF_STALL_CNT_EN adds stall_cnt_o[15:0].
module mem_rd_streamer #(
  parameter int ADDR_WIDTH = 7,
  parameter int NUM_WORDS  = 100,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  mem_rd_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_last_o
`ifdef PERF_STALL_CNT_EN
  ,
  output logic [15:0]           stall_cnt_o
`endif
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(NUM_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic                    inflight_q;
  logic                    infl_last_q;
  logic [1:0]              occ_q;
  logic [1:0]              occ_d;
  logic [1:0]              wr_pos;
  logic [DATA_WIDTH-1:0]   data_q [2];
  logic [1:0]              last_q;
  logic                    push;
  logic                    pop;
  logic                    is_last_addr;
  logic [2:0]              credit_used;
  logic [2:0]              credit_max;
  logic                    credit_ok;

  assign pop          = m_valid_o && m_ready_i;
  assign push         = inflight_q;
  assign m_valid_o    = (occ_q != 2'd0);
  assign m_data_o     = data_q[0];
  assign m_last_o     = m_valid_o && last_q[0];
  assign busy_o       = (state_q != IDLE);
  assign mem_addr_o   = addr_q;
  assign is_last_addr = (addr_q == LAST_ADDR);

  // Slots already claimed: stored words plus the read landing next
  // edge. A word leaving this cycle hands its slot back at once.
  assign credit_used = {1'b0, occ_q} + {2'b00, inflight_q};
  assign credit_max  = 3'd2 + {2'b00, pop};
  assign credit_ok   = (credit_used < credit_max);

  // Write position after the head (if popped) shifts out.
  assign wr_pos = occ_q - {1'b0, pop};
  assign occ_d  = occ_q + {1'b0, push} - {1'b0, pop};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    mem_rd_o = 1'b0;
    done_o   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = RUN;
          addr_d  = '0;
        end
      end
      RUN: begin
        if (credit_ok) begin
          mem_rd_o = 1'b1;
          addr_d   = addr_q + ADDR_WIDTH'(1);
          if (is_last_addr) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if ((occ_q == 2'd0) && !inflight_q) begin
          done_o  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      inflight_q  <= 1'b0;
      infl_last_q <= 1'b0;
      occ_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      inflight_q  <= mem_rd_o;
      infl_last_q <= mem_rd_o && is_last_addr;
      occ_q       <= occ_d;
    end
  end

  // Payload needs no reset: it is only seen when occ_q says so.
  // A push after a pop overrides the shifted slot, keeping order.
  always_ff @(posedge clk) begin
    if (pop) begin
      data_q[0] <= data_q[1];
      last_q[0] <= last_q[1];
    end
    if (push) begin
      data_q[wr_pos[0]] <= mem_rdata_i;
      last_q[wr_pos[0]] <= infl_last_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && (occ_q == 2'd2)));
      assert (occ_q != 2'd3);
    end
  end

`ifdef PERF_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= 16'd0;
    end else if ((state_q == IDLE) && start_i) begin
      stall_q <= 16'd0;
    end else if (m_valid_o && !m_ready_i &&
                 (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_mem_rd_streamer.sv
// tb_mem_rd_streamer: directed bench for mem_rd_streamer with a
// scoreboard of expected words and SRAM models for three configs.
module tb_mem_rd_streamer;

  localparam int NW = 100;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start, busy, done, mem_rd, valid, ready, last;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] rdata, data;

  logic          s1_start, busy1, done1, rd1, valid1, ready1, last1;
  logic [AW-1:0] addr1;
  logic [DW-1:0] rdata1, data1;

  logic          s2_start, busy2, done2, rd2, valid2, ready2, last2;
  logic [AW-1:0] addr2;
  logic [DW-1:0] rdata2, data2;

`ifdef PERF_STALL_CNT_EN
  logic [15:0] stall, stall1, stall2;
`endif

  always @(posedge clk) if (mem_rd) rdata <= DW'(mem_addr);
  always @(posedge clk) if (rd1) rdata1 <= 32'hC0DE_0000 | DW'(addr1);
  always @(posedge clk) if (rd2) rdata2 <= DW'(addr2);

  mem_rd_streamer #(.ADDR_WIDTH(AW), .NUM_WORDS(NW), .DATA_WIDTH(DW)) u0 (
    .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
    .mem_rd_o(mem_rd), .mem_addr_o(mem_addr), .mem_rdata_i(rdata),
    .m_valid_o(valid), .m_ready_i(ready), .m_data_o(data), .m_last_o(last)
`ifdef PERF_STALL_CNT_EN
    , .stall_cnt_o(stall)
`endif
  );

  mem_rd_streamer #(.ADDR_WIDTH(AW), .NUM_WORDS(1), .DATA_WIDTH(DW)) u1 (
    .clk(clk), .rst(rst), .start_i(s1_start), .busy_o(busy1), .done_o(done1),
    .mem_rd_o(rd1), .mem_addr_o(addr1), .mem_rdata_i(rdata1),
    .m_valid_o(valid1), .m_ready_i(ready1), .m_data_o(data1), .m_last_o(last1)
`ifdef PERF_STALL_CNT_EN
    , .stall_cnt_o(stall1)
`endif
  );

  mem_rd_streamer #(.ADDR_WIDTH(AW), .NUM_WORDS(128), .DATA_WIDTH(DW)) u2 (
    .clk(clk), .rst(rst), .start_i(s2_start), .busy_o(busy2), .done_o(done2),
    .mem_rd_o(rd2), .mem_addr_o(addr2), .mem_rdata_i(rdata2),
    .m_valid_o(valid2), .m_ready_i(ready2), .m_data_o(data2), .m_last_o(last2)
`ifdef PERF_STALL_CNT_EN
    , .stall_cnt_o(stall2)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [DW:0] sb [$];
  int rd_exp, issued, accepted, last_cnt;
  int first_valid = -1;
  int last_cyc = -1;
  int xfer_start = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic hold = 1'b0;
  logic [DW-1:0] hold_data;
  logic hold_last;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Observes u0 mid-cycle: scoreboard, address order, hold, credit.
  task automatic mon0();
    logic [DW:0] e;
    if (rst) begin
      sb.delete();
      hold = 1'b0;
      issued = 0;
      accepted = 0;
      return;
    end
    if (start && !busy) begin
      for (int i = 0; i < NW; i++)
        sb.push_back({(i == NW - 1), DW'(i)});
      rd_exp = 0;
      issued = 0;
      accepted = 0;
      last_cnt = 0;
      first_valid = -1;
      last_cyc = -1;
      xfer_start = cyc;
    end
    if (hold) begin
      chk("hold_valid", valid, 1);
      chk("hold_data", data, hold_data);
      chk("hold_last", last, hold_last);
    end
    hold = valid && !ready;
    hold_data = data;
    hold_last = last;
    if (mem_rd) begin
      chk("rd_addr", mem_addr, rd_exp);
      rd_exp++;
      issued++;
    end
    if (valid && first_valid < 0) first_valid = cyc;
    if (valid && ready) begin
      chk("sb_has_entry", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("data", data, e[DW-1:0]);
        chk("last", last, e[DW]);
      end
      accepted++;
      if (last) begin
        last_cnt++;
        last_cyc = cyc;
      end
    end
    chk("credit", (issued - accepted) <= 2, 1);
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      chk("done_sb_empty", sb.size(), 0);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    mon0();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_done(int budget);
    int d0 = done_cnt;
    int n = 0;
    while (done_cnt == d0 && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt - d0, 1);
  endtask

  initial begin
    int n;
    int d0;
    int cnt;
    int rdc;
    start = 0; ready = 0;
    s1_start = 0; ready1 = 1;
    s2_start = 0; ready2 = 1;
    @(posedge clk);
    #1;
    tick();
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd", mem_rd, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_last", last, 0);
    rst = 0;
    tick();
    tick();

    // full-rate transfer and latency
    ready = 1;
    start = 1;
    tick();
    start = 0;
    wait_done(300);
    chk("lat_first_valid", first_valid - xfer_start, 3);
    chk("lat_last", last_cyc - xfer_start, 102);
    chk("lat_done", done_cyc - xfer_start, 103);
    chk("full_issued", issued, NW);
    chk("full_accepted", accepted, NW);
    chk("full_last_cnt", last_cnt, 1);
    chk("full_sb_empty", sb.size(), 0);
    chk("full_idle", busy, 0);

    // back-to-back start, then reset at word 40
    start = 1;
    tick();
    start = 0;
    chk("b2b_busy", busy, 1);
    n = 0;
    while (accepted < 40 && n < 200) begin
      tick();
      n++;
    end
    chk("reach_40", accepted, 40);
    rst = 1;
    tick();
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_rd", mem_rd, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_last", last, 0);
    rst = 0;
    tick();
    tick();
    chk("post_rst_valid", valid, 0);
    chk("post_rst_busy", busy, 0);
    start = 1;
    tick();
    start = 0;
    wait_done(300);
    chk("restart_accepted", accepted, NW);
    chk("restart_lat", first_valid - xfer_start, 3);

    // backpressure from cycle 2 for 10 cycles
    start = 1;
    tick();
    start = 0;
    tick();
    ready = 0;
    repeat (10) tick();
    chk("bp_issued", issued, 2);
    chk("bp_valid", valid, 1);
    chk("bp_data", data, 0);
    ready = 1;
    wait_done(300);
    chk("bp_accepted", accepted, NW);

    // random ready
    start = 1;
    tick();
    start = 0;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      ready = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    ready = 1;
    chk("rnd_done", done_cnt - d0, 1);
    chk("rnd_accepted", accepted, NW);
    chk("rnd_last_cnt", last_cnt, 1);
    chk("rnd_sb_empty", sb.size(), 0);
    repeat (3) tick();
    chk("rnd_one_done", done_cnt - d0, 1);

    // start pulses during RUN and DRAIN are ignored
    start = 1;
    tick();
    start = 0;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < 2000) begin
      start = (n % 7 == 3) || (issued == NW);
      ready = (n % 5 != 0);
      tick();
      n++;
    end
    start = 0;
    ready = 1;
    chk("ign_accepted", accepted, NW);
    chk("ign_last_cnt", last_cnt, 1);
    repeat (3) tick();
    chk("ign_one_done", done_cnt - d0, 1);
    chk("ign_idle", busy, 0);

    // NUM_WORDS = 1
    s1_start = 1;
    tick();
    s1_start = 0;
    chk("n1_rd", rd1, 1);
    chk("n1_addr", addr1, 0);
    chk("n1_busy", busy1, 1);
    tick();
    chk("n1_no_2nd_rd", rd1, 0);
    chk("n1_not_valid", valid1, 0);
    tick();
    chk("n1_valid", valid1, 1);
    chk("n1_data", data1, 32'hC0DE_0000);
    chk("n1_last", last1, 1);
    tick();
    chk("n1_done", done1, 1);
    chk("n1_empty", valid1, 0);
    tick();
    chk("n1_done_pulse", done1, 0);
    chk("n1_idle", busy1, 0);

    // NUM_WORDS = 2^ADDR_WIDTH ends on the all-ones address
    s2_start = 1;
    tick();
    s2_start = 0;
    cnt = 0;
    rdc = 0;
    n = 0;
    while (!done2 && n < 400) begin
      if (rd2) begin
        chk("n128_addr", addr2, rdc);
        rdc++;
      end
      if (valid2) begin
        chk("n128_data", data2, cnt);
        chk("n128_last", last2, cnt == 127);
        cnt++;
      end
      tick();
      n++;
    end
    chk("n128_done", done2, 1);
    chk("n128_words", cnt, 128);
    chk("n128_reads", rdc, 128);
    tick();

`ifdef PERF_STALL_CNT_EN
    start = 1;
    tick();
    start = 0;
    n = 0;
    while (first_valid < 0 && n < 20) begin
      tick();
      n++;
    end
    ready = 0;
    repeat (7) tick();
    chk("stall_7", stall, 7);
    ready = 1;
    wait_done(300);
    chk("stall_hold", stall, 7);
    start = 1;
    tick();
    start = 0;
    chk("stall_clear", stall, 0);
    wait_done(300);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
